cpc_romsel_n: RTL and testbench
===============================

Name: cpc_romsel_n

Overview:
- Clocked, parametrised upper-ROM selector for CPC expansion boards; the successor to the fixed eight-slot DIP-strapped board.
- Decodes CPC ROM-select I/O writes (IOREQ_B=0, WR_B=0, A13=0) and maps NUM_SLOTS consecutive ROM numbers onto paired 32K EEPROMs.
- Drives per-device chip selects, the in-device bank address and ROMDIS.
- Adds a timed unlock sequence on a dedicated control port, which arms EEPROM in-system writes with a generated write-enable pulse.

Parameters:
- NUM_SLOTS, 8, number of ROM slots served; power of two, 2..32.
- SLOTS_PER_DEV, 2, 16K slots per physical device; power of two, at most NUM_SLOTS.
- BASE_SLOT, 0, first ROM number served; multiple of NUM_SLOTS.
- CTRL_PORT, 16'hFBE0, full 16-bit I/O address of the control port.
- UNLOCK_TIMEOUT, 255, max CLK cycles allowed between unlock writes.
- WE_PULSE_CYCLES, 2, rom_we_b low time in CLK cycles, at least 1.

Ports:
- CLK in 1: CPC bus clock; all state updates on the rising edge.
- RESET_B in 1: asynchronous, active-low reset.
- A in 16: Z80 address bus.
- D in 8: Z80 data bus, sampled on writes only.
- IOREQ_B in 1: Z80 I/O request, active low.
- MREQ_B in 1: Z80 memory request, active low.
- WR_B in 1: Z80 write strobe, active low.
- ROMEN_B in 1: CPC ROM enable, active low.
- slot_en in NUM_SLOTS: per-slot enable straps; bit i=1 enables slot BASE_SLOT+i.
- rom_cs_b out NUM_SLOTS/SLOTS_PER_DEV: per-device chip select, active low.
- rom_bank out max(1,log2(SLOTS_PER_DEV)): device high address bits, equal to the low bits of the slot index.
- rom_we_b out 1: shared EEPROM write enable, active low.
- romdis out 1: ROMDIS drive, active high; the board diode is external.
- we_armed out 1: status, EEPROM write mode enabled.

Behaviour:
- Reset values (RESET_B low, effective immediately):
  - rom_sel=0, unlock FSM=IDLE, timeout counter=0, we_en=0, pulse counter=0.
  - Outputs: rom_cs_b all 1, rom_bank=0, rom_we_b=1, romdis=0, we_armed=0.
- Strobe edge detect:
  - io_wr = ~IOREQ_B & ~WR_B, registered each cycle.
  - An I/O write is "new" on the first cycle io_wr is high after a cycle where it was low.
  - Exactly one action per bus cycle, even if WR_B stays low for several clocks.
- ROM select:
  - A new io_wr with A13=0 loads rom_sel<=D at that edge.
  - rom_sel is visible to the decode one cycle later.
- Slot hit:
  - hit = (rom_sel - BASE_SLOT) < NUM_SLOTS, using 8-bit unsigned arithmetic, AND slot_en[rom_sel-BASE_SLOT].
  - hit is computed from the registered rom_sel; a ROM number outside the range or with a disabled slot gives hit=0.
- Read decode (combinational, for access time):
  - acc = hit & ~ROMEN_B & A[14].
  - rom_cs_b[idx/SLOTS_PER_DEV] = ~acc, where idx is the slot index; all other chip selects are held at 1.
  - romdis = acc.
  - rom_bank = idx mod SLOTS_PER_DEV, driven whenever hit=1.
- Unlock FSM: states IDLE -> U1 -> U2 -> ARMED, advancing only on new I/O writes where A==CTRL_PORT.
  - IDLE: D=8'h55 moves to U1.
  - U1: D=8'hAA moves to U2.
  - U2: D=8'hC3 moves to ARMED and sets we_en=1.
  - Any other D on CTRL_PORT returns to IDLE; in ARMED, any D clears we_en and returns to IDLE.
  - The timeout counter clears on each advancing write and counts while in U1 or U2. Reaching UNLOCK_TIMEOUT returns the FSM to IDLE.
  - A ROM-select write does not disturb the FSM. A13 is 1 at CTRL_PORT, so there is no overlap with ROM-select writes.
  - we_armed = we_en.
- Write pulse:
  - Triggered by a new memory write (~MREQ_B & ~WR_B edge, detected the same way as io_wr) with A[15:14]=2'b11, hit=1 and we_en=1.
  - rom_we_b goes low on the next edge for WE_PULSE_CYCLES cycles.
  - rom_cs_b for the target device is held low for the whole pulse, independent of ROMEN_B.
  - New memory-write triggers during a pulse are ignored.
  - Writes to ROMs when we_en=0 produce no pulse; RAM shadow writes are unaffected.
- Simultaneous events:
  - A ROM-select write during a pulse updates rom_sel, but the pulse keeps the device latched at its start.
  - Reset mid-pulse forces rom_we_b=1 immediately.

Test Plan:
- Reset, then OUT &DF00,5 with BASE_SLOT=0, slot_en=8'hFF -> rom_sel=5 one cycle later. A read at &C000 with ROMEN_B=0 gives rom_cs_b=4'b1011, rom_bank=1, romdis=1. With A14=0, all chip selects are 1 and romdis=0.
- OUT &DF00,9 (out of range), then OUT &DF00,3 with slot_en[3]=0 -> both leave all rom_cs_b=1 and romdis=0 on upper-ROM reads.
- WR_B held low 3 cycles on OUT &DF00,2 -> a single load; verify the edge detector prevents retrigger.
- OUT &FBE0 with 55, AA, C3 -> we_armed=1. A memory write to &C123 with rom_sel=6 gives rom_we_b low 2 cycles and rom_cs_b[3]=0. A fourth CTRL_PORT write clears we_armed.
- Send 55 then AA, wait 256 cycles, send C3 -> we_armed stays 0. Sending 55, 12, AA, C3 also leaves we_armed=0.
- Assert RESET_B low mid-write-pulse -> rom_we_b=1, we_armed=0, rom_sel=0 asynchronously.

Source files
------------

// File: rtl/cpc_romsel_n_if.sv
// CPU-side bus and board-side outputs of the upper-ROM selector.
// Instantiate with the same slot parameters as the selector it connects to.
interface cpc_romsel_n_if #(
  parameter int unsigned NumSlots    = 8,
  parameter int unsigned SlotsPerDev = 2
);
  localparam int unsigned NumDev = NumSlots / SlotsPerDev;
  localparam int unsigned BankW  = (SlotsPerDev > 1) ? $clog2(SlotsPerDev) : 1;

  logic [15:0]         a;
  logic [7:0]          d;
  logic                ioreq_b;
  logic                mreq_b;
  logic                wr_b;
  logic                romen_b;
  logic [NumSlots-1:0] slot_en;
  logic [NumDev-1:0]   rom_cs_b;
  logic [BankW-1:0]    rom_bank;
  logic                rom_we_b;
  logic                romdis;
  logic                we_armed;

  modport master (
    output a, d, ioreq_b, mreq_b, wr_b, romen_b, slot_en,
    input  rom_cs_b, rom_bank, rom_we_b, romdis, we_armed
  );

  modport slave (
    input  a, d, ioreq_b, mreq_b, wr_b, romen_b, slot_en,
    output rom_cs_b, rom_bank, rom_we_b, romdis, we_armed
  );
endinterface

// File: rtl/cpc_romsel_n.sv
// Upper-ROM selector for CPC expansion boards: maps ROM-select writes onto paired EEPROMs
// and arms in-system EEPROM writes after a timed unlock sequence on a control port.
module cpc_romsel_n #(
  parameter int unsigned NumSlots      = 8,
  parameter int unsigned SlotsPerDev   = 2,
  parameter int unsigned BaseSlot      = 0,
  parameter logic [15:0] CtrlPort      = 16'hFBE0,
  parameter int unsigned UnlockTimeout = 255,
  parameter int unsigned WePulseCycles = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  cpc_romsel_n_if.slave bus_io
);
  localparam int unsigned NumDev   = NumSlots / SlotsPerDev;
  localparam int unsigned IdxW     = $clog2(NumSlots);
  localparam int unsigned DevShift = $clog2(SlotsPerDev);
  localparam int unsigned BankW    = (SlotsPerDev > 1) ? $clog2(SlotsPerDev) : 1;
  localparam int unsigned DevW     = (NumDev > 1) ? $clog2(NumDev) : 1;
  localparam int unsigned TmoW     = $clog2(UnlockTimeout + 1);
  localparam int unsigned PulseW   = $clog2(WePulseCycles + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StU1    = 2'd1;
  localparam logic [1:0] StU2    = 2'd2;
  localparam logic [1:0] StArmed = 2'd3;

  logic              io_wr, io_wr_q, io_new;
  logic              mem_wr, mem_wr_q, mem_new;
  logic [7:0]        rom_sel_q, rom_sel_d;
  logic [1:0]        st_q, st_d, st_eff;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              we_en_q, we_en_d;
  logic [PulseW-1:0] pulse_q, pulse_d;
  logic [IdxW-1:0]   pidx_q, pidx_d;

  logic [7:0]        off;
  logic              in_range, hit, acc, pulse_on, trig;
  logic              ctrl_wr, unlocking, timed_out;
  logic [IdxW-1:0]   idx, use_idx;
  logic [DevW-1:0]   dev;
  logic [NumDev-1:0] cs;
  logic [BankW-1:0]  bank;

  // One action per bus cycle: only the first clock of a low strobe counts.
  assign io_wr   = ~bus_io.ioreq_b & ~bus_io.wr_b;
  assign mem_wr  = ~bus_io.mreq_b & ~bus_io.wr_b;
  assign io_new  = io_wr & ~io_wr_q;
  assign mem_new = mem_wr & ~mem_wr_q;

  assign rom_sel_d = (io_new && !bus_io.a[13]) ? bus_io.d : rom_sel_q;

  always_comb begin
    off      = rom_sel_q - 8'(BaseSlot);
    in_range = off < 8'(NumSlots);
    idx      = off[IdxW-1:0];
    hit      = in_range & bus_io.slot_en[idx];
    acc      = hit & ~bus_io.romen_b & bus_io.a[14];
    pulse_on = pulse_q != '0;
    // A running write pulse keeps the device it started on, whatever rom_sel does meanwhile.
    use_idx  = pulse_on ? pidx_q : idx;
    dev      = DevW'(use_idx >> DevShift);
    cs       = '1;
    bank     = '0;
    if (pulse_on) begin
      cs   = ~(NumDev'(1) << dev);
      bank = (SlotsPerDev > 1) ? BankW'(use_idx) : '0;
    end else begin
      if (acc) cs = ~(NumDev'(1) << dev);
      if (hit && SlotsPerDev > 1) bank = BankW'(use_idx);
    end
  end

  always_comb begin
    trig    = mem_new && (bus_io.a[15:14] == 2'b11) && hit && we_en_q && !pulse_on;
    pulse_d = pulse_q;
    pidx_d  = pidx_q;
    if (trig) begin
      pulse_d = PulseW'(WePulseCycles);
      pidx_d  = idx;
    end else if (pulse_on) begin
      pulse_d = pulse_q - PulseW'(1);
    end
  end

  // A write landing on the timeout cycle is judged from IDLE, not from the stale state.
  always_comb begin
    ctrl_wr   = io_new && (bus_io.a == CtrlPort);
    unlocking = (st_q == StU1) || (st_q == StU2);
    timed_out = unlocking && (tmo_q == TmoW'(UnlockTimeout));
    st_eff    = timed_out ? StIdle : st_q;
    st_d      = st_eff;
    tmo_d     = (unlocking && !timed_out) ? tmo_q + TmoW'(1) : '0;
    we_en_d   = we_en_q;
    if (ctrl_wr) begin
      tmo_d = '0;
      unique case (st_eff)
        StIdle:  st_d = (bus_io.d == 8'h55) ? StU1 : StIdle;
        StU1:    st_d = (bus_io.d == 8'hAA) ? StU2 : StIdle;
        StU2: begin
          st_d    = (bus_io.d == 8'hC3) ? StArmed : StIdle;
          we_en_d = (bus_io.d == 8'hC3);
        end
        default: begin
          st_d    = StIdle;
          we_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      io_wr_q   <= 1'b0;
      mem_wr_q  <= 1'b0;
      rom_sel_q <= '0;
      st_q      <= StIdle;
      tmo_q     <= '0;
      we_en_q   <= 1'b0;
      pulse_q   <= '0;
      pidx_q    <= '0;
    end else begin
      io_wr_q   <= io_wr;
      mem_wr_q  <= mem_wr;
      rom_sel_q <= rom_sel_d;
      st_q      <= st_d;
      tmo_q     <= tmo_d;
      we_en_q   <= we_en_d;
      pulse_q   <= pulse_d;
      pidx_q    <= pidx_d;
    end
  end

  assign bus_io.rom_cs_b = cs;
  assign bus_io.rom_bank = bank;
  assign bus_io.rom_we_b = ~pulse_on;
  assign bus_io.romdis   = acc;
  assign bus_io.we_armed = we_en_q;
endmodule

// File: tb/tb_cpc_romsel_n.sv
// Directed plus randomized bench for cpc_romsel_n against a behavioural model of the
// ROM-select, unlock and write-pulse rules.
module tb_cpc_romsel_n;
  localparam int unsigned N    = 8;
  localparam int unsigned SPD  = 2;
  localparam int unsigned BASE = 0;
  localparam int unsigned TMO  = 255;
  localparam int unsigned WE   = 2;
  localparam int unsigned NDEV = N / SPD;
  localparam logic [15:0] CTRL = 16'hFBE0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cpc_romsel_n_if #(.NumSlots(N), .SlotsPerDev(SPD)) bus ();

  cpc_romsel_n #(
    .NumSlots     (N),
    .SlotsPerDev  (SPD),
    .BaseSlot     (BASE),
    .CtrlPort     (CTRL),
    .UnlockTimeout(TMO),
    .WePulseCycles(WE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  // Model state: selected ROM number, unlock progress, and remaining write-pulse cycles.
  int m_sel, m_stage, m_last, m_pulse, m_pidx;
  bit m_armed;
  int cyc;
  int n_total, n_pass, n_fail;

  function automatic int m_off();
    return (m_sel - int'(BASE)) & 255;
  endfunction

  function automatic bit m_hit();
    int off;
    off = m_off();
    if (off < int'(N)) return bus.slot_en[off[2:0]];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NDEV-1:0] e_cs;
    int e_bank, off;
    bit acc;
    off    = m_off();
    acc    = m_hit() && !bus.romen_b && bus.a[14];
    e_cs   = '1;
    e_bank = 0;
    if (m_pulse > 0) begin
      e_cs   = ~(NDEV'(1) << (m_pidx / int'(SPD)));
      e_bank = m_pidx % int'(SPD);
    end else begin
      if (acc) e_cs = ~(NDEV'(1) << (off / int'(SPD)));
      if (m_hit()) e_bank = off % int'(SPD);
    end
    check({tag, ".cs"},    32'(bus.rom_cs_b), 32'(e_cs));
    check({tag, ".bank"},  32'(bus.rom_bank), 32'(e_bank));
    check({tag, ".romdis"}, 32'(bus.romdis),  32'(acc));
    check({tag, ".we_b"},  32'(bus.rom_we_b), 32'(m_pulse == 0));
    check({tag, ".armed"}, 32'(bus.we_armed), 32'(m_armed));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (m_pulse > 0) m_pulse--;
    #1;
  endtask

  task automatic model_ctrl(input logic [7:0] dv);
    if ((m_stage == 1 || m_stage == 2) && (cyc - m_last > int'(TMO))) m_stage = 0;
    case (m_stage)
      0: if (dv == 8'h55) begin m_stage = 1; m_last = cyc; end
      1: if (dv == 8'hAA) begin m_stage = 2; m_last = cyc; end else m_stage = 0;
      2: if (dv == 8'hC3) begin m_stage = 3; m_armed = 1'b1; end else m_stage = 0;
      default: begin m_stage = 0; m_armed = 1'b0; end
    endcase
  endtask

  // I/O write held low for nlow clocks; data changes after the first clock.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] d0,
                          input logic [7:0] drest, input int nlow);
    bus.a = addr; bus.d = d0; bus.ioreq_b = 1'b0; bus.wr_b = 1'b0;
    tick();
    if (!addr[13]) m_sel = int'(d0);
    if (addr == CTRL) model_ctrl(d0);
    bus.d = drest;
    for (int i = 1; i < nlow; i++) tick();
    bus.ioreq_b = 1'b1; bus.wr_b = 1'b1;
    tick();
    check_all("io");
  endtask

  task automatic io1(input logic [15:0] addr, input logic [7:0] dv);
    io_write(addr, dv, dv, 1);
  endtask

  task automatic mem_write(input logic [15:0] addr, input int nlow);
    bit trig;
    bus.romen_b = 1'b1; bus.a = addr; bus.mreq_b = 1'b0; bus.wr_b = 1'b0;
    #1;
    trig = (addr[15:14] == 2'b11) && m_hit() && m_armed && (m_pulse == 0);
    tick();
    if (trig) begin m_pulse = int'(WE); m_pidx = m_off(); end
    check_all("memwr");
    for (int i = 1; i < nlow; i++) begin tick(); check_all("memhold"); end
    bus.mreq_b = 1'b1; bus.wr_b = 1'b1;
    repeat (WE + 1) begin tick(); check_all("mempost"); end
  endtask

  task automatic rd(input logic [15:0] addr, input logic romen, input string tag);
    bus.a = addr; bus.romen_b = romen;
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic model_reset();
    m_sel = 0; m_stage = 0; m_armed = 1'b0; m_pulse = 0; m_last = 0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; cyc = 0; m_pidx = 0;
    model_reset();
    bus.a = '0; bus.d = '0; bus.ioreq_b = 1'b1; bus.mreq_b = 1'b1; bus.wr_b = 1'b1;
    bus.romen_b = 1'b1; bus.slot_en = 8'hFF;
    #1 rst_n = 1'b0;
    #2 check_all("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    io1(16'hDF00, 8'd5);
    bus.a = 16'hC000; bus.romen_b = 1'b0; #1;
    check("sel5.cs_literal", 32'(bus.rom_cs_b), 32'h0000000B);
    rd(16'hC000, 1'b0, "sel5_rd");
    rd(16'h8000, 1'b0, "sel5_a14lo");
    rd(16'hC000, 1'b1, "sel5_romen_hi");

    io1(16'hDF00, 8'd9);
    rd(16'hC000, 1'b0, "sel9_range");
    bus.slot_en = 8'hF7;
    io1(16'hDF00, 8'd3);
    rd(16'hC000, 1'b0, "sel3_disabled");
    bus.slot_en = 8'hFF;
    rd(16'hC000, 1'b0, "sel3_enabled");

    // Data changes while WR_B stays low; only the first clock may load.
    io_write(16'hDF00, 8'd2, 8'd4, 3);
    rd(16'hC000, 1'b0, "sel2_held");

    io1(CTRL, 8'h55); io1(CTRL, 8'hAA); io1(CTRL, 8'hC3);
    check("armed_after_unlock", 32'(bus.we_armed), 32'd1);
    io1(16'hDF00, 8'd6);
    mem_write(16'hC123, 4);
    io1(CTRL, 8'h00);
    mem_write(16'hC123, 1);

    // Gap of 255 cycles between AA and C3 is the last one that still arms.
    io1(CTRL, 8'h55); io1(CTRL, 8'hAA);
    repeat (253) tick();
    io1(CTRL, 8'hC3);
    io1(CTRL, 8'h00);
    io1(CTRL, 8'h55); io1(CTRL, 8'hAA);
    repeat (254) tick();
    io1(CTRL, 8'hC3);
    io1(CTRL, 8'h55); io1(CTRL, 8'hAA);
    repeat (256) tick();
    io1(CTRL, 8'hC3);
    io1(CTRL, 8'h55); io1(CTRL, 8'h12); io1(CTRL, 8'hAA); io1(CTRL, 8'hC3);

    io1(CTRL, 8'h55); io1(CTRL, 8'hAA); io1(CTRL, 8'hC3);
    for (int i = 0; i < 160; i++) begin
      int op;
      op = $urandom_range(0, 4);
      case (op)
        0: io1(16'($urandom) & 16'hDFFF,
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, N + 3)));
        1: rd(16'($urandom), 1'($urandom), "rand_rd");
        2: bus.slot_en = 8'($urandom);
        3: mem_write(($urandom_range(0, 3) == 0) ? 16'($urandom) : {2'b11, 14'($urandom)},
                     $urandom_range(1, 3));
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            io1(CTRL, 8'h55); io1(CTRL, 8'hAA); io1(CTRL, 8'hC3);
          end else begin
            io1(CTRL, 8'($urandom));
          end
        end
      endcase
    end

    // Reset in the middle of a write pulse.
    bus.slot_en = 8'hFF;
    io1(CTRL, 8'h00);
    io1(CTRL, 8'h55); io1(CTRL, 8'hAA); io1(CTRL, 8'hC3);
    io1(16'hDF00, 8'd6);
    bus.romen_b = 1'b1; bus.a = 16'hC123; bus.mreq_b = 1'b0; bus.wr_b = 1'b0;
    tick();
    m_pulse = int'(WE); m_pidx = m_off();
    check_all("pulse_pre_rst");
    bus.mreq_b = 1'b1; bus.wr_b = 1'b1;
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_mid_pulse");
    check("rst_we_b", 32'(bus.rom_we_b), 32'd1);
    rd(16'hC000, 1'b0, "rst_sel0");
    rst_n = 1'b1;
    tick();
    rd(16'hC000, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
